// File: rtl/pga_agc_controller.sv
// Automatic gain control loop: measures windowed peak |sample| and steps the PGA gain
// through the PGA controller's Int/Gain/Done handshake, settling after every write.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// INIT      | after reset, wait for Enable to program GainInit once
// REQ       | PgaGain stable, raise PgaInt
// WAIT_DONE | hold PgaInt until PgaDone or timeout
// SETTLE    | PgaInt low, ignore samples for SettleCycles
// MEASURE   | track peak |sample| over WindowLen valid samples
// DECIDE    | compare peak with thresholds, maybe request a gain step
// IDLE      | loop disabled, wait for Enable
module pga_agc_controller #(
    parameter int         SampleWidth   = 12,
    parameter int         WindowLen     = 1024,
    parameter int         HighThresh    = 1800,
    parameter int         LowThresh     = 600,
    parameter int         SettleCycles  = 4096,
    parameter int         TimeoutCycles = 65535,
    parameter logic [2:0] GainInit      = 3'd0
) (
    input  logic                   Reset_n,
    input  logic                   Clk,
    input  logic                   Enable,
    input  logic                   SampleValid,
    input  logic [SampleWidth-1:0] Sample,
    output logic                   PgaInt,
    output logic [2:0]             PgaGain,
    input  logic                   PgaDone,
    output logic [2:0]             Gain,
    output logic [SampleWidth-1:0] Peak,
    output logic                   Locked,
    output logic                   Error
);

    localparam int TMR_MAX = (SettleCycles > TimeoutCycles) ? SettleCycles : TimeoutCycles;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int CW      = $clog2(WindowLen + 1);

    localparam logic [TW-1:0]          TIMEOUT_LOAD = TW'(TimeoutCycles - 1);
    localparam logic [TW-1:0]          SETTLE_LOAD  = TW'(SettleCycles - 1);
    localparam logic [CW-1:0]          WIN_LOAD     = CW'(WindowLen - 1);
    localparam logic [SampleWidth-1:0] HIGH_T       = SampleWidth'(HighThresh);
    localparam logic [SampleWidth-1:0] LOW_T        = SampleWidth'(LowThresh);
    localparam logic [SampleWidth-1:0] ONE_S        = SampleWidth'(1);

    typedef enum logic [2:0] {
        S_INIT,
        S_REQ,
        S_WAIT_DONE,
        S_SETTLE,
        S_MEASURE,
        S_DECIDE,
        S_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic                   pga_int_q, pga_int_d;
    logic [2:0]             pga_gain_q, pga_gain_d;
    logic [2:0]             gain_q, gain_d;
    logic [SampleWidth-1:0] peak_q, peak_d;
    logic                   locked_q, locked_d;
    logic                   error_q, error_d;
    logic [SampleWidth-1:0] max_q, max_d;
    logic [CW-1:0]          win_cnt_q, win_cnt_d;
    logic [TW-1:0]          timer_q, timer_d;

    logic [SampleWidth-1:0] sample_abs;
    logic [SampleWidth-1:0] max_next;
    logic                   leave_to_idle;

    // Unsigned magnitude: the most-negative code maps to 2^(SampleWidth-1) exactly.
    assign sample_abs = Sample[SampleWidth-1] ? ((~Sample) + ONE_S) : Sample;
    assign max_next   = (sample_abs > max_q) ? sample_abs : max_q;

    // A running SPI handshake is never abandoned; only these states react to Enable=0.
    assign leave_to_idle = !Enable &&
                           ((state_q == S_SETTLE) || (state_q == S_MEASURE) || (state_q == S_DECIDE));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_INIT;
            pga_int_q  <= 1'b0;
            pga_gain_q <= GainInit;
            gain_q     <= GainInit;
            peak_q     <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
            max_q      <= '0;
            win_cnt_q  <= WIN_LOAD;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            pga_int_q  <= pga_int_d;
            pga_gain_q <= pga_gain_d;
            gain_q     <= gain_d;
            peak_q     <= peak_d;
            locked_q   <= locked_d;
            error_q    <= error_d;
            max_q      <= max_d;
            win_cnt_q  <= win_cnt_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pga_int_d  = pga_int_q;
        pga_gain_d = pga_gain_q;
        gain_d     = gain_q;
        peak_d     = peak_q;
        locked_d   = locked_q;
        error_d    = error_q;
        max_d      = max_q;
        win_cnt_d  = win_cnt_q;
        timer_d    = timer_q;

        if (leave_to_idle) begin
            state_d   = S_IDLE;
            max_d     = '0;
            win_cnt_d = WIN_LOAD;
            locked_d  = 1'b0;
            error_d   = 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (Enable) begin
                        pga_gain_d = GainInit;
                        state_d    = S_REQ;
                    end
                end
                S_REQ: begin
                    pga_int_d = 1'b1;
                    timer_d   = TIMEOUT_LOAD;
                    state_d   = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (PgaDone) begin
                        pga_int_d = 1'b0;
                        gain_d    = pga_gain_q;
                        timer_d   = SETTLE_LOAD;
                        state_d   = S_SETTLE;
                    end else if (timer_q == '0) begin
                        pga_int_d = 1'b0;
                        error_d   = 1'b1;
                        timer_d   = SETTLE_LOAD;
                        state_d   = S_SETTLE;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_SETTLE: begin
                    max_d     = '0;
                    win_cnt_d = WIN_LOAD;
                    if (timer_q == '0) begin
                        state_d = S_MEASURE;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_MEASURE: begin
                    if (SampleValid) begin
                        if (win_cnt_q == '0) begin
                            peak_d    = max_next;
                            max_d     = '0;
                            win_cnt_d = WIN_LOAD;
                            state_d   = S_DECIDE;
                        end else begin
                            max_d     = max_next;
                            win_cnt_d = win_cnt_q - CW'(1);
                        end
                    end
                end
                S_DECIDE: begin
                    // Thresholds are exclusive: a peak equal to either one counts as locked.
                    if (peak_q > HIGH_T) begin
                        locked_d = 1'b0;
                        if (gain_q != 3'd0) begin
                            pga_gain_d = gain_q - 3'd1;
                            state_d    = S_REQ;
                        end else begin
                            state_d = S_MEASURE;
                        end
                    end else if (peak_q < LOW_T) begin
                        locked_d = 1'b0;
                        if (gain_q != 3'd7) begin
                            pga_gain_d = gain_q + 3'd1;
                            state_d    = S_REQ;
                        end else begin
                            state_d = S_MEASURE;
                        end
                    end else begin
                        locked_d = 1'b1;
                        state_d  = S_MEASURE;
                    end
                end
                S_IDLE: begin
                    if (Enable) begin
                        state_d = S_MEASURE;
                    end
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

    assign PgaInt  = pga_int_q;
    assign PgaGain = pga_gain_q;
    assign Gain    = gain_q;
    assign Peak    = peak_q;
    assign Locked  = locked_q;
    assign Error   = error_q;

endmodule

// File: doc/pga_agc_controller.md
Name: pga_agc_controller

Overview:
- Automatic gain control loop directly upstream of the PGA SPI controller.
- Measures peak absolute amplitude of received ADC samples over fixed windows and steps the 3-bit PGA gain up or down.
- Issues each gain change through the PGA controller's Int/Gain/Done handshake, then waits a settle period before measuring again.
- Reports the applied gain, a lock indication and a sticky handshake-timeout error.

Parameters:
- SampleWidth, 12, width of signed two's-complement ADC samples.
- WindowLen, 1024, valid samples per measurement window (2..65535).
- HighThresh, 1800, peak above this lowers gain one step (unsigned, SampleWidth bits).
- LowThresh, 600, peak below this raises gain one step; must be < HighThresh.
- SettleCycles, 4096, Clk cycles to wait after a completed gain write (>= 4).
- TimeoutCycles, 65535, Clk cycles allowed for PgaDone after a request.
- GainInit, 0, gain programmed after reset.

Ports:
- Reset_n  in  1  asynchronous, active-low reset.
- Clk  in  1  system clock, same clock as the PGA controller.
- Enable  in  1  loop enable; level-sensitive.
- SampleValid  in  1  Sample qualifier; one sample per high cycle.
- Sample  in  SampleWidth  signed ADC sample.
- PgaInt  out  1  gain-write request to the PGA controller (rising edge triggers).
- PgaGain  out  3  gain code presented with PgaInt.
- PgaDone  in  1  one-cycle completion pulse from the PGA controller.
- Gain  out  3  last successfully applied gain.
- Peak  out  SampleWidth  peak of the last completed window.
- Locked  out  1  last window peak within [LowThresh, HighThresh].
- Error  out  1  sticky PgaDone timeout flag.

Behaviour:
- Reset values: PgaInt=0, PgaGain=GainInit, Gain=GainInit, Peak=0, Locked=0, Error=0, state INIT.
- States: INIT, REQ, WAIT_DONE, SETTLE, MEASURE, DECIDE, IDLE.
- INIT: on the first Clk with Enable=1, load PgaGain=GainInit and go to REQ. It programs the PGA once after reset.
- REQ: PgaGain is already stable from the previous cycle. Assert PgaInt=1, go to WAIT_DONE. PgaGain must not change while PgaInt=1.
- WAIT_DONE: hold PgaInt=1 and count Clk cycles.
  - On PgaDone=1: PgaInt<=0, Gain<=PgaGain, go to SETTLE.
  - If the count reaches TimeoutCycles first: PgaInt<=0, Error<=1, Gain unchanged, go to SETTLE.
- SETTLE: PgaInt=0 for SettleCycles Clk cycles, ignoring samples, then go to MEASURE. This guarantees PgaInt is low for at least SettleCycles between requests.
- MEASURE: per SampleValid cycle:
  - abs = Sample<0 ? -Sample : Sample, computed as unsigned SampleWidth bits. The most-negative value maps to 2^(SampleWidth-1) without overflow.
  - Running max is updated with abs.
  - After WindowLen valid samples: Peak<=max, clear max and count, go to DECIDE.
  - Cycles with SampleValid=0 do not count.
- DECIDE: one cycle.
  - Peak>HighThresh and Gain>0: PgaGain<=Gain-1, Locked<=0, go to REQ.
  - Peak<LowThresh and Gain<7: PgaGain<=Gain+1, Locked<=0, go to REQ.
  - Out of range at a gain limit (0 or 7): no request, Locked<=0, go to MEASURE.
  - In range (including equality with either threshold): Locked<=1, go to MEASURE.
  - Gain never wraps.
- Enable=0:
  - From MEASURE, DECIDE or SETTLE: go to IDLE, clear window max/count and Locked, clear Error.
  - In REQ or WAIT_DONE: the handshake completes or times out first, then the block goes to IDLE. The SPI cycle is never aborted.
  - In INIT: the block stays in INIT.
- IDLE: on Enable=1, go to MEASURE with a fresh window.
- A PgaDone pulse outside WAIT_DONE is ignored.
- Reset mid-operation returns all outputs to reset values immediately. PgaInt drops asynchronously.

Test Plan:
- Reset, Enable=1, PgaDone pulsed 20 cycles after PgaInt rises -> PgaInt high exactly until the Done cycle, PgaGain=0 throughout, Gain=0 after Done, no further PgaInt for 4096 cycles.
- Windows of +/-300 sine samples (peak 300) from gain 0 with prompt Done -> gain steps 1,2,...,7, one request per window; at 7 no request issued, Locked=0.
- Single sample -2048 in a window, HighThresh=1800, Gain=3 -> Peak=2048, PgaGain=2 requested.
- Window peak exactly 1800 and exactly 600 -> Locked=1, no PgaInt edge.
- PgaDone withheld -> PgaInt falls after 65535 cycles, Error=1, Gain unchanged. A later request with Done returned -> Gain updates and Error stays 1 until Enable=0.
- Enable dropped mid-WAIT_DONE -> PgaInt held until Done, then IDLE. Enable dropped mid-MEASURE -> IDLE within 1 cycle, Locked=0.
